// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_arbiter
// Description : Arbitrates icache/dcache block requests onto a single memory
//               port, one transaction in flight, with dcache anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl_arbiter #(
    parameter int BLOCK_ADDR_WIDTH = 26,
    parameter int BLOCK_DATA_WIDTH = 64,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        icache_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
    output logic                        icache_req_ready,
    input  logic                        icache_flush,
    output logic                        icache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,

    input  logic                        dcache_req_valid,
    input  logic                        dcache_req_type,
    input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
    output logic                        dcache_req_ready,
    output logic                        dcache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data,

    output logic                        mem_req_valid,
    output logic                        mem_req_type,
    output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data
);

    localparam int c_cnt_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    logic [1:0]                  r_state;
    logic                        r_owner_d;
    logic                        r_type;
    logic                        r_drop;
    logic [BLOCK_ADDR_WIDTH-1:0] r_addr;
    logic [BLOCK_DATA_WIDTH-1:0] r_data;
    logic [c_cnt_w-1:0]          r_starve_cnt;

    logic w_in_idle;
    logic w_in_issue;
    logic w_in_wait;
    logic w_i_eligible;
    logic w_d_wins;
    logic w_i_fire;
    logic w_d_fire;
    logic w_resp;
    logic w_i_resp;
    logic w_d_resp;
    logic w_flush_hit;

    // Reset gates every output so nothing leaks from stale state while rst is high.
    assign w_in_idle  = !rst && (r_state == c_st_idle);
    assign w_in_issue = !rst && (r_state == c_st_issue);
    assign w_in_wait  = !rst && (r_state == c_st_wait);

    assign w_i_eligible = icache_req_valid && !icache_flush;
    assign w_d_wins     = dcache_req_valid &&
                          (!w_i_eligible || (r_starve_cnt == c_starve_max));

    assign icache_req_ready = w_in_idle && !icache_flush && !w_d_wins;
    assign dcache_req_ready = w_in_idle && w_d_wins;

    assign w_i_fire = icache_req_valid && icache_req_ready;
    assign w_d_fire = dcache_req_valid && dcache_req_ready;

    assign mem_req_valid      = w_in_issue;
    assign mem_req_type       = w_in_issue ? r_type : 1'b0;
    assign mem_req_block_addr = w_in_issue ? r_addr : '0;
    assign mem_req_block_data = w_in_issue ? r_data : '0;

    // A flush arriving in the same cycle as the fill still kills that fill.
    assign w_resp   = w_in_wait && mem_resp_valid;
    assign w_i_resp = w_resp && !r_owner_d && !r_drop && !icache_flush;
    assign w_d_resp = w_resp && r_owner_d;

    assign icache_resp_valid      = w_i_resp;
    assign icache_resp_block_data = w_i_resp ? mem_resp_block_data : '0;
    assign dcache_resp_valid      = w_d_resp;
    assign dcache_resp_block_data = w_d_resp ? mem_resp_block_data : '0;

    assign w_flush_hit = icache_flush && !r_owner_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_owner_d    <= 1'b0;
            r_type       <= 1'b0;
            r_drop       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_drop <= 1'b0;
                    if (w_i_fire) begin
                        r_state   <= c_st_issue;
                        r_owner_d <= 1'b0;
                        r_type    <= 1'b0;
                        r_addr    <= icache_req_block_addr;
                        r_data    <= '0;
                        if (dcache_req_valid && (r_starve_cnt != c_starve_max))
                            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
                    end else if (w_d_fire) begin
                        r_state      <= c_st_issue;
                        r_owner_d    <= 1'b1;
                        r_type       <= dcache_req_type;
                        r_addr       <= dcache_req_block_addr;
                        r_data       <= dcache_req_block_data;
                        r_starve_cnt <= '0;
                    end
                end
                c_st_issue: begin
                    if (w_flush_hit)
                        r_drop <= 1'b1;
                    if (mem_req_ready)
                        r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (mem_resp_valid) begin
                        r_state <= c_st_idle;
                        r_drop  <= 1'b0;
                    end else if (w_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl_arbiter.md
MEM_CTRL_ARBITER -- requirements
Module: mem_ctrl_arbiter

Interface
REQ-001 SHALL have parameters: BLOCK_ADDR_WIDTH, default 26, main-memory block address width; BLOCK_DATA_WIDTH, default 64, block data width; STARVE_LIMIT, default 4, maximum consecutive icache grants while dcache waits.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: icache_req_valid  in  1; icache_req_block_addr  in  BLOCK_ADDR_WIDTH; icache_req_ready  out  1: icache block read request.
REQ-005 SHALL have ports: icache_flush  in  1  fetch redirect; discards any in-flight icache response.
REQ-006 SHALL have ports: icache_resp_valid  out  1; icache_resp_block_data  out  BLOCK_DATA_WIDTH: icache fill.
REQ-007 SHALL have ports: dcache_req_valid  in  1; dcache_req_type  in  1 (0 read, 1 write); dcache_req_block_addr  in  BLOCK_ADDR_WIDTH; dcache_req_block_data  in  BLOCK_DATA_WIDTH; dcache_req_ready  out  1.
REQ-008 SHALL have ports: dcache_resp_valid  out  1; dcache_resp_block_data  out  BLOCK_DATA_WIDTH: read fill or write ack.
REQ-009 SHALL have ports: mem_req_valid  out  1; mem_req_type  out  1; mem_req_block_addr  out  BLOCK_ADDR_WIDTH; mem_req_block_data  out  BLOCK_DATA_WIDTH; mem_req_ready  in  1.
REQ-010 SHALL have ports: mem_resp_valid  in  1; mem_resp_block_data  in  BLOCK_DATA_WIDTH: one response per accepted request, reads and writes.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-012 In IDLE, SHALL grant at most one requester per cycle; grant = combinational assertion of that requester's req_ready; transfer occurs on valid && ready.
REQ-013 Priority SHALL be icache over dcache, except dcache wins when both valid and starve_cnt == STARVE_LIMIT.
REQ-014 icache_req_ready SHALL be 0 whenever icache_flush = 1; dcache may be granted that cycle instead.
REQ-015 On grant, SHALL latch owner (I/D), type (icache forced read), block addr, block data, and go to ISSUE next cycle.
REQ-016 starve_cnt (saturating, width clog2(STARVE_LIMIT+1)) SHALL increment on icache grant with dcache_req_valid = 1, clear on dcache grant, otherwise hold.
REQ-017 In ISSUE, mem_req_valid SHALL be 1 with latched fields held stable until mem_req_ready = 1; then go to WAIT next cycle.
REQ-018 In WAIT, on mem_resp_valid = 1, SHALL forward mem_resp_block_data combinationally, same cycle, to the owner's resp_valid/resp_block_data, then return to IDLE next cycle.
REQ-019 Write responses SHALL pulse dcache_resp_valid for one cycle; data value is don't-care.
REQ-020 drop flag SHALL set when icache_flush = 1 while owner = I in ISSUE or WAIT; while set, the icache response is consumed but icache_resp_valid stays 0; flag clears on return to IDLE.
REQ-021 Flush SHALL NOT retract a request in ISSUE; it still issues and its response is dropped.
REQ-022 mem_resp_valid outside WAIT SHALL be ignored; resp_valid outputs are 0 outside WAIT.
REQ-023 Minimum turnaround: grant cycle N, mem_req_valid from N+1, next grant no earlier than the cycle after the response.
REQ-024 mem_resp_valid and icache_flush in the same WAIT cycle with owner I SHALL drop that response.

Reset
REQ-025 rst = 1 SHALL force state IDLE, starve_cnt 0, drop 0, owner I, latched fields 0 on the next edge, including mid-transaction; in-flight responses are abandoned.
REQ-026 During and after reset all outputs SHALL be 0 (req_ready, resp_valid, mem_req_valid, data/addr).

Verification
REQ-027 Icache alone: addr 0x10, mem_req_ready = 1 at N+1, resp 0xDEADBEEF at N+4 -> mem_req_valid N+1 only, icache_resp_valid at N+4 with 0xDEADBEEF, icache_req_ready again at N+5.
REQ-028 Both valid from reset, icache always valid, STARVE_LIMIT = 4 -> grants I,I,I,I,D; starve_cnt returns to 0 after D.
REQ-029 Backpressure: mem_req_ready low 3 cycles -> mem_req_valid/addr/data stable 4 cycles, no new grant.
REQ-030 icache_flush during WAIT -> mem response consumed, icache_resp_valid stays 0, IDLE next cycle, drop cleared.
REQ-031 dcache write addr 0x20 data 0x1234 -> mem_req_type 1 with data 0x1234; mem_resp_valid -> one-cycle dcache_resp_valid.
REQ-032 rst asserted in WAIT, then mem_resp_valid -> no resp_valid; IDLE; new icache request granted.
